// File: rtl/layer_scheduler.sv
// layer_scheduler: fixed-priority sharing of one sprite-memory read port among
// NUM_LAYERS drawing layers, plus the once-per-frame vertical-blank config window.
// Latency: 1 cycle from sampled request to mem_addr/grant_valid; all outputs registered.
// Backpressure: none on the pixel path; the config writer is gated by cfg_req/cfg_ack
// and force-closed (cfg_abort) one line before the next frame.
//
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   pixel_x, pixel_y      current raster position from the sync generator
//   req_en, req_addr      per-layer request and address (layer i at [i*ADDR_W +: ADDR_W])
//   mem_addr, grant_valid, grant_id   registered arbitration result
//   cfg_req, cfg_ack, cfg_done, cfg_abort   config-window handshake
//   frame_start           pulse the cycle after (0,0) is sampled
//   collision             per-layer overlap flags of the previous frame
//
// Optional feature macro: LAYER_COLLISION_EN (collision accumulator; otherwise collision=0).

module layer_scheduler #(
  parameter int NUM_LAYERS = 4,
  parameter int ADDR_W     = 10,
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int V_TOTAL    = 628
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  pixel_x,
  input  logic [9:0]                   pixel_y,
  input  logic [NUM_LAYERS-1:0]        req_en,
  input  logic [NUM_LAYERS*ADDR_W-1:0] req_addr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         grant_valid,
  output logic [2:0]                   grant_id,
  input  logic                         cfg_req,
  output logic                         cfg_ack,
  input  logic                         cfg_done,
  output logic                         cfg_abort,
  output logic                         frame_start,
  output logic [NUM_LAYERS-1:0]        collision
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_VBLANK, ST_GRANT, ST_LOCKED} state_t;

  state_t state, state_nxt;
  logic   ack_nxt, abort_nxt, enter_blank;

  logic line_active, pix_active, at_origin, force_close;
  // Previous sample was on a visible line; makes VBLANK entry edge-triggered so a
  // reset taken inside blanking waits for the next real transition into blanking.
  logic prev_line_active;

  assign line_active = (pixel_y < V_ACT);
  assign pix_active  = line_active && (pixel_x < H_ACT);
  assign at_origin   = (pixel_x == 11'd0) && (pixel_y == 10'd0);
  assign force_close = (pixel_y == V_LAST) && (pixel_x == 11'd0);

  // Lowest requesting index wins: scan downward so the lowest set bit is written last.
  logic              win_found;
  logic [2:0]        win_id;
  logic [ADDR_W-1:0] win_addr;

  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    win_addr  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req_en[i]) begin
        win_found = 1'b1;
        win_id    = 3'(i);
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ack_nxt     = cfg_ack;
    abort_nxt   = 1'b0;
    enter_blank = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (!line_active && prev_line_active) begin
          state_nxt   = ST_VBLANK;
          enter_blank = 1'b1;
        end
      end
      ST_VBLANK: begin
        // Origin wins over a late request; no grant on the closing line, since
        // the forced close at its x=0 would otherwise be missed.
        if (at_origin) begin
          state_nxt = ST_ACTIVE;
        end else if (cfg_req && (pixel_y < V_LAST)) begin
          state_nxt = ST_GRANT;
          ack_nxt   = 1'b1;
        end
      end
      ST_GRANT: begin
        // cfg_done on the forced-close cycle counts as a clean finish.
        if (cfg_done) begin
          state_nxt = ST_LOCKED;
          ack_nxt   = 1'b0;
        end else if (force_close) begin
          state_nxt = ST_LOCKED;
          ack_nxt   = 1'b0;
          abort_nxt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (at_origin) state_nxt = ST_ACTIVE;
      end
      default: begin
        state_nxt = ST_ACTIVE;
        ack_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_ACTIVE;
      cfg_ack          <= 1'b0;
      cfg_abort        <= 1'b0;
      frame_start      <= 1'b0;
      prev_line_active <= 1'b0;
      mem_addr         <= '0;
      grant_valid      <= 1'b0;
      grant_id         <= 3'd0;
    end else begin
      state            <= state_nxt;
      cfg_ack          <= ack_nxt;
      cfg_abort        <= abort_nxt;
      frame_start      <= at_origin;
      prev_line_active <= line_active;
      grant_valid      <= pix_active && win_found;
      if (pix_active && win_found) begin
        mem_addr <= win_addr;
        grant_id <= win_id;
      end
    end
  end

`ifdef LAYER_COLLISION_EN
  logic [NUM_LAYERS-1:0] coll_acc, coll_q;
  logic                  multi_req;

  assign multi_req = ($countones(req_en) >= 2);

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_acc <= '0;
      coll_q   <= '0;
    end else if (enter_blank) begin
      // Snapshot is held for the whole blanking window for the writer to read.
      coll_q   <= coll_acc;
      coll_acc <= '0;
    end else if (pix_active && multi_req) begin
      coll_acc <= coll_acc | req_en;
    end
  end

  assign collision = coll_q;
`else
  assign collision = '0;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
module tb_layer_scheduler;
  localparam int N  = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   pixel_x;
  logic [9:0]    pixel_y;
  logic [N-1:0]  req_en;
  logic [N*AW-1:0] req_addr;
  logic [AW-1:0] mem_addr;
  logic          grant_valid;
  logic [2:0]    grant_id;
  logic          cfg_req, cfg_ack, cfg_done, cfg_abort, frame_start;
  logic [N-1:0]  collision;

  int total = 0;
  int bad   = 0;

  layer_scheduler #(.NUM_LAYERS(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .req_en(req_en), .req_addr(req_addr), .mem_addr(mem_addr),
    .grant_valid(grant_valid), .grant_id(grant_id), .cfg_req(cfg_req),
    .cfg_ack(cfg_ack), .cfg_done(cfg_done), .cfg_abort(cfg_abort),
    .frame_start(frame_start), .collision(collision)
  );

  always #5 clk = ~clk;

`ifdef LAYER_COLLISION_EN
  localparam bit COLL_ON = 1'b1;
`else
  localparam bit COLL_ON = 1'b0;
`endif

  // Behavioural reference: expected outputs after the next clock edge.
  logic [AW-1:0] m_addr;
  logic          m_gv, m_ack, m_abort, m_fs;
  logic [2:0]    m_gid;
  logic [N-1:0]  m_coll, m_acc;
  bit            m_blank;     // somewhere inside this frame's blanking period
  bit            m_used;      // this frame's window already granted and closed
  bit            m_prev_vis;  // previous sample was on a visible line

  task automatic model_update();
    int x, y;
    bit origin;
    x = int'(pixel_x);
    y = int'(pixel_y);
    origin = (x == 0) && (y == 0);
    if (reset) begin
      m_addr = '0; m_gv = 0; m_gid = 0; m_ack = 0; m_abort = 0; m_fs = 0;
      m_coll = '0; m_acc = '0; m_blank = 0; m_used = 0; m_prev_vis = 0;
      return;
    end
    m_gv = 0;
    if (x < 800 && y < 600) begin
      for (int i = 0; i < N; i++) begin
        if (req_en[i]) begin
          m_gv = 1; m_gid = 3'(i); m_addr = req_addr[i*AW +: AW];
          break;
        end
      end
    end
    m_fs = origin;
    m_abort = 0;
    if (!m_blank) begin
      if (y >= 600 && m_prev_vis) begin
        m_blank = 1; m_used = 0;
        if (COLL_ON) begin m_coll = m_acc; m_acc = '0; end
      end
    end else if (m_ack) begin
      if (cfg_done) begin m_ack = 0; m_used = 1; end
      else if (y == 627 && x == 0) begin m_ack = 0; m_used = 1; m_abort = 1; end
    end else if (origin) begin
      m_blank = 0;
    end else if (!m_used && cfg_req && y < 627) begin
      m_ack = 1;
    end
    if (COLL_ON && x < 800 && y < 600 && $countones(req_en) >= 2) m_acc = m_acc | req_en;
    m_prev_vis = (y < 600);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pixel_x = 11'(x);
    pixel_y = 10'(y);
    step();
  endtask

  task automatic do_reset();
    reset = 1; pixel_x = 0; pixel_y = 0; req_en = 0;
    step();
    reset = 0;
  endtask

  task automatic enter_blank();
    pix(0, 0);
    pix(10, 599);
    pix(0, 600);
  endtask

  task automatic test_reset();
    reset = 1; req_en = 4'b1111; req_addr = 40'h12345_6789A; cfg_req = 1; cfg_done = 0;
    pixel_x = 5; pixel_y = 5;
    step();
    total++; if (mem_addr !== 0)    begin bad++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
    total++; if (grant_valid !== 0) begin bad++; $display("FAIL reset_gv got %0b want 0", grant_valid); end
    total++; if (grant_id !== 0)    begin bad++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    total++; if (cfg_ack !== 0 || cfg_abort !== 0 || frame_start !== 0)
      begin bad++; $display("FAIL reset_cfg got ack=%0b abort=%0b fs=%0b want 0", cfg_ack, cfg_abort, frame_start); end
    total++; if (collision !== 0)   begin bad++; $display("FAIL reset_coll got %0b want 0", collision); end
    reset = 0; cfg_req = 0; req_en = 0;
  endtask

  task automatic test_priority();
    req_addr = '0;
    req_addr[1*AW +: AW] = 10'h005;
    req_addr[3*AW +: AW] = 10'h3FF;
    req_en = 4'b1010;
    pix(100, 10);
    total++; if (grant_valid !== 1) begin bad++; $display("FAIL prio_gv got %0b want 1", grant_valid); end
    total++; if (grant_id !== 1)    begin bad++; $display("FAIL prio_gid got %0d want 1", grant_id); end
    total++; if (mem_addr !== 10'h005) begin bad++; $display("FAIL prio_addr got %0h want 5", mem_addr); end
  endtask

  task automatic test_blanking();
    req_addr[0 +: AW] = 10'h123;
    req_en = 4'b0001;
    pix(10, 600);
    total++; if (grant_valid !== 0) begin bad++; $display("FAIL blank_gv got %0b want 0", grant_valid); end
    total++; if (mem_addr !== 10'h005) begin bad++; $display("FAIL blank_addr got %0h want 5", mem_addr); end
    req_en = 0;
  endtask

  task automatic test_normal_window();
    do_reset();
    pix(0, 0);
    total++; if (frame_start !== 1) begin bad++; $display("FAIL frame_start got %0b want 1", frame_start); end
    pix(10, 599);
    pix(0, 600);
    cfg_req = 1;
    pix(0, 601);
    total++; if (cfg_ack !== 1) begin bad++; $display("FAIL win_ack_open got %0b want 1", cfg_ack); end
    pix(0, 605);
    total++; if (cfg_ack !== 1) begin bad++; $display("FAIL win_ack_hold got %0b want 1", cfg_ack); end
    cfg_done = 1;
    pix(0, 610);
    cfg_done = 0;
    total++; if (cfg_ack !== 0 || cfg_abort !== 0)
      begin bad++; $display("FAIL win_done got ack=%0b abort=%0b want 0 0", cfg_ack, cfg_abort); end
    cfg_req = 0;
    pix(0, 612);
    cfg_req = 1;
    pix(0, 615);
    pix(5, 615);
    total++; if (cfg_ack !== 0) begin bad++; $display("FAIL win_second_req got %0b want 0", cfg_ack); end
    cfg_req = 0;
    pix(0, 627);
    total++; if (cfg_abort !== 0) begin bad++; $display("FAIL win_no_abort got %0b want 0", cfg_abort); end
    pix(0, 0);
  endtask

  task automatic test_forced_close();
    do_reset();
    enter_blank();
    cfg_req = 1;
    pix(0, 620);
    total++; if (cfg_ack !== 1) begin bad++; $display("FAIL force_ack_open got %0b want 1", cfg_ack); end
    pix(0, 626);
    total++; if (cfg_ack !== 1 || cfg_abort !== 0)
      begin bad++; $display("FAIL force_pre got ack=%0b abort=%0b want 1 0", cfg_ack, cfg_abort); end
    pix(0, 627);
    total++; if (cfg_ack !== 0 || cfg_abort !== 1)
      begin bad++; $display("FAIL force_close got ack=%0b abort=%0b want 0 1", cfg_ack, cfg_abort); end
    pix(1, 627);
    total++; if (cfg_abort !== 0) begin bad++; $display("FAIL force_pulse_once got %0b want 0", cfg_abort); end
    cfg_req = 0;
    enter_blank();
    cfg_req = 1;
    pix(0, 620);
    total++; if (cfg_ack !== 1) begin bad++; $display("FAIL force2_ack got %0b want 1", cfg_ack); end
    cfg_done = 1;
    pix(0, 627);
    cfg_done = 0;
    total++; if (cfg_ack !== 0 || cfg_abort !== 0)
      begin bad++; $display("FAIL force_done_same got ack=%0b abort=%0b want 0 0", cfg_ack, cfg_abort); end
    pix(1, 627);
    total++; if (cfg_abort !== 0) begin bad++; $display("FAIL force_done_after got %0b want 0", cfg_abort); end
    cfg_req = 0;
  endtask

  task automatic test_collision();
    logic [N-1:0] exp;
    exp = COLL_ON ? 4'b0101 : 4'b0000;
    do_reset();
    pix(0, 0);
    req_en = 4'b0101;
    pix(5, 5);
    req_en = 0;
    pix(6, 5);
    pix(10, 599);
    pix(0, 600);
    total++; if (collision !== exp) begin bad++; $display("FAIL coll_set got %0b want %0b", collision, exp); end
    pix(300, 615);
    total++; if (collision !== exp) begin bad++; $display("FAIL coll_stable got %0b want %0b", collision, exp); end
    pix(0, 0);
    req_en = 4'b0100;
    pix(5, 5);
    req_en = 4'b0001;
    pix(7, 5);
    req_en = 0;
    pix(10, 599);
    pix(0, 600);
    total++; if (collision !== 0) begin bad++; $display("FAIL coll_clear got %0b want 0", collision); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    enter_blank();
    cfg_req = 1;
    pix(0, 601);
    total++; if (cfg_ack !== 1) begin bad++; $display("FAIL rst_grant_open got %0b want 1", cfg_ack); end
    reset = 1;
    pix(0, 605);
    reset = 0;
    total++; if (cfg_ack !== 0 || cfg_abort !== 0)
      begin bad++; $display("FAIL rst_grant_ack got ack=%0b abort=%0b want 0 0", cfg_ack, cfg_abort); end
    for (int y = 606; y <= 627; y++) begin
      pix(0, y);
      total++; if (cfg_ack !== 0) begin bad++; $display("FAIL rst_no_grant y=%0d got %0b want 0", y, cfg_ack); end
    end
    enter_blank();
    pix(0, 601);
    total++; if (cfg_ack !== 1) begin bad++; $display("FAIL rst_next_frame got %0b want 1", cfg_ack); end
    cfg_req = 0;
    cfg_done = 1;
    pix(0, 602);
    cfg_done = 0;
  endtask

  task automatic test_random();
    int x, y, ny;
    x = 0; y = 0;
    for (int n = 0; n < 1500; n++) begin
      ny = y + int'($urandom_range(0, 12));
      if (ny > 627 && y != 627) begin y = 627; x = 0; end
      else if (ny > 627) begin y = 0; x = 0; end
      else begin
        y = ny;
        x = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 900));
      end
      req_en   = N'($urandom);
      req_addr = {$urandom, $urandom};
      cfg_req  = ($urandom_range(0, 1) == 1);
      cfg_done = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      pix(x, y);
      total++; if (grant_valid !== m_gv) begin bad++; $display("FAIL rnd_gv n=%0d got %0b want %0b", n, grant_valid, m_gv); end
      total++; if (grant_id !== m_gid)   begin bad++; $display("FAIL rnd_gid n=%0d got %0d want %0d", n, grant_id, m_gid); end
      total++; if (mem_addr !== m_addr)  begin bad++; $display("FAIL rnd_addr n=%0d got %0h want %0h", n, mem_addr, m_addr); end
      total++; if (cfg_ack !== m_ack)    begin bad++; $display("FAIL rnd_ack n=%0d got %0b want %0b", n, cfg_ack, m_ack); end
      total++; if (cfg_abort !== m_abort) begin bad++; $display("FAIL rnd_abort n=%0d got %0b want %0b", n, cfg_abort, m_abort); end
      total++; if (frame_start !== m_fs) begin bad++; $display("FAIL rnd_fs n=%0d got %0b want %0b", n, frame_start, m_fs); end
      total++; if (collision !== m_coll) begin bad++; $display("FAIL rnd_coll n=%0d got %0b want %0b", n, collision, m_coll); end
    end
    reset = 0; cfg_req = 0; cfg_done = 0; req_en = 0;
  endtask

  initial begin
    reset = 1; pixel_x = 0; pixel_y = 0; req_en = 0; req_addr = '0;
    cfg_req = 0; cfg_done = 0;
    test_reset();
    test_priority();
    test_blanking();
    test_normal_window();
    test_forced_close();
    test_collision();
    test_reset_mid_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Per-pixel scheduler for the VGA console's sprite datapath. It shares one sprite-memory read port among up to NUM_LAYERS drawing layers, using fixed priority. Layer 0 is the barrier layer, which presents an enable and a 10-bit block address. The block also sequences a once-per-frame vertical-blank window in which an external configuration writer (the game controller) may update sprite and position registers without tearing.

## Interface
- NUM_LAYERS, 4, number of requesting layers (2..8); index 0 has highest priority
- ADDR_W, 10, sprite-memory address width
- H_ACTIVE, 800, visible pixels per line
- V_ACTIVE, 600, visible lines per frame
- V_TOTAL, 628, total lines per frame including blanking
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pixel_x  in  11  current horizontal pixel from the sync generator
- pixel_y  in  10  current line from the sync generator
- req_en  in  NUM_LAYERS  per-layer pixel request (the layer's enable)
- req_addr  in  NUM_LAYERS*ADDR_W  per-layer address; layer i occupies bits [i*ADDR_W +: ADDR_W]
- mem_addr  out  ADDR_W  address to the shared sprite memory
- grant_valid  out  1  mem_addr is valid for the current pixel
- grant_id  out  3  index of the granted layer
- cfg_req  in  1  configuration writer requests the update window (level)
- cfg_ack  out  1  window is open; writer may update
- cfg_done  in  1  one-cycle pulse: writer has finished
- cfg_abort  out  1  one-cycle pulse: window force-closed before cfg_done
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- collision  out  NUM_LAYERS  per-layer overlap flags for the previous frame

## Operation
- The active region is pixel_y < V_ACTIVE and pixel_x < H_ACTIVE. Arbitration takes place only in this region.
- Arbitration, every active cycle:
  - The lowest index i with req_en[i]=1 wins.
  - Registered outputs: mem_addr <= req_addr of layer i, grant_id <= i, grant_valid <= 1.
- If no layer requests, or the pixel is outside the active region, grant_valid <= 0. mem_addr and grant_id hold their previous values.
- Window FSM states: ACTIVE, VBLANK, GRANT, LOCKED.
  - ACTIVE → VBLANK on the first cycle with pixel_y >= V_ACTIVE.
  - VBLANK → GRANT when cfg_req=1; cfg_ack <= 1.
  - GRANT → LOCKED on cfg_done; cfg_ack <= 0.
  - GRANT → LOCKED when pixel_y == V_TOTAL-1 && pixel_x == 0 and cfg_done has not arrived. cfg_ack <= 0 and cfg_abort pulses for one cycle.
  - VBLANK and LOCKED → ACTIVE when pixel_y == 0 && pixel_x == 0.
  - There is at most one grant per frame. cfg_req asserted in ACTIVE or LOCKED waits for the next VBLANK.
- Simultaneous events:
  - cfg_done arriving in the same cycle as the forced close counts as done, so no abort is issued.
  - cfg_req rising on the last VBLANK cycle before (0,0) is not granted.
- frame_start is registered: it is 1 in the cycle after the sample at which pixel_x==0 && pixel_y==0.
- Reset mid-frame:
  - FSM returns to ACTIVE and all outputs take their reset values.
  - If the reset occurs during vertical blank, the first VBLANK detection happens at the next transition into blanking.
- Reset values: mem_addr=0, grant_valid=0, grant_id=0, cfg_ack=0, cfg_abort=0, frame_start=0, collision=0.

## Timing
- Grant latency is 1 cycle: the request is sampled on posedge N and mem_addr/grant_valid are valid after posedge N. The memory read then adds its own latency downstream.
- cfg_ack rises 1 cycle after cfg_req is sampled in VBLANK. It falls 1 cycle after cfg_done is sampled, or at the forced close.
- Every output is registered; there is no combinational path from inputs to outputs.
- The window closes one full line (V_TOTAL-1) before the next frame, which gives the writer's outputs a settling margin.

## Configuration
- LAYER_COLLISION_EN defined:
  - An internal accumulator ORs in req_en during every active cycle in which two or more layers request.
  - On the ACTIVE→VBLANK transition, collision <= accumulator and the accumulator is cleared in the same cycle.
  - collision is stable for the whole blanking window, so the writer can read it while cfg_ack is high.
- LAYER_COLLISION_EN undefined: collision is constant 0 and the accumulator logic is absent.

## Test plan
- Priority:
  - Stimulus: pixel (100,10), req_en=4'b1010, addr1=0x05, addr3=0x3FF.
  - Required: next cycle grant_valid=1, grant_id=1, mem_addr=0x05.
- Blanking suppression:
  - Stimulus: req_en=4'b0001 at pixel_y=600.
  - Required: grant_valid=0 and mem_addr holds its prior value.
- Normal window:
  - Stimulus: cfg_req at pixel_y=601, then cfg_done at pixel_y=610.
  - Required: cfg_ack=1 from the following cycle; cfg_ack=0 one cycle after cfg_done; cfg_abort never pulses; a second cfg_req at pixel_y=615 gets no ack.
- Forced close:
  - Stimulus: cfg_req at pixel_y=620 with no cfg_done.
  - Required: at pixel_y=627, pixel_x=0, cfg_ack drops and cfg_abort pulses once; a cfg_done arriving in the same cycle suppresses the abort.
- Collision (LAYER_COLLISION_EN): layers 0 and 2 requesting together at pixel (5,5) → collision=4'b0101 after entry into vblank; the next frame with no overlaps → collision=0.
- Reset mid-GRANT: reset held for 1 cycle at pixel_y=605 → cfg_ack=0, FSM in ACTIVE, no grant until the next frame's blanking.
